// File: rtl/pebb_pkg.sv
// Shared packet-framing definitions: header field layout, framer states and
// a header builder, reused by the framer and the router.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef KEEP_WIDTH
`define KEEP_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif
`ifndef DEST_WIDTH
`define DEST_WIDTH 8
`endif

package pebb_pkg;

    localparam int HDR_W        = 64;
    localparam int HDR_FIELD_W  = 8;
    localparam int HDR_DEST_LSB = 56;
    localparam int HDR_SRC_LSB  = 48;
    localparam int HDR_LEN_LSB  = 40;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } framer_state_t;

    // Header beat: dest, source, payload length, remaining bits zero.
    function automatic logic [HDR_W-1:0] make_header(
        input logic [HDR_FIELD_W-1:0] dest,
        input logic [HDR_FIELD_W-1:0] src,
        input logic [HDR_FIELD_W-1:0] len
    );
        logic [HDR_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_DEST_LSB +: HDR_FIELD_W] = dest;
        hdr[HDR_SRC_LSB  +: HDR_FIELD_W] = src;
        hdr[HDR_LEN_LSB  +: HDR_FIELD_W] = len;
        return hdr;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream pipeline register driving the framed output.
// Handshake: a beat moves when valid and ready are both high on a rising edge;
// once valid is high it stays high with stable payload until that transfer.
module axis_out_reg #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int ID_W   = 8,
    parameter int DEST_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [KEEP_W-1:0] in_keep_i,
    input  logic              in_last_i,
    input  logic [ID_W-1:0]   in_id_i,
    input  logic [DEST_W-1:0] in_dest_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [KEEP_W-1:0] out_keep_o,
    output logic              out_last_o,
    output logic [ID_W-1:0]   out_id_o,
    output logic [DEST_W-1:0] out_dest_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;
    logic              last_q;
    logic [ID_W-1:0]   id_q;
    logic [DEST_W-1:0] dest_q;

    // Accept a new beat when empty or when the held beat leaves this cycle.
    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
            dest_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            keep_q  <= in_keep_i;
            last_q  <= in_last_i;
            id_q    <= in_id_i;
            dest_q  <= in_dest_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_keep_o  = keep_q;
    assign out_last_o  = last_q;
    assign out_id_o    = id_q;
    assign out_dest_o  = dest_q;

endmodule

// File: rtl/pkt_framer.sv
// Packet framer: prepends a header beat to a counted payload stream.
// Define PKT_FRAMER_ERRCNT_EN to add the err_count payload-tlast checker.
module pkt_framer
    import pebb_pkg::*;
#(
    parameter logic [7:0] ADDRESS = 8'h00
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_dest,
    input  logic [7:0]             cmd_len,
    input  logic [`DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [`KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [`DATA_WIDTH-1:0] m_axis_tdata,
    output logic [`KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [`ID_WIDTH-1:0]   m_axis_tid,
    output logic [`DEST_WIDTH-1:0] m_axis_tdest,
    output logic                   busy,
`ifdef PKT_FRAMER_ERRCNT_EN
    output logic [15:0]            err_count,
`endif
    output framer_state_t          dbg_state
);

    framer_state_t          state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [`DEST_WIDTH-1:0] dest_q, dest_d;

    logic                   out_ready;
    logic                   cmd_fire;
    logic                   pay_fire;
    logic                   load_valid;
    logic [`DATA_WIDTH-1:0] load_data;
    logic [`KEEP_WIDTH-1:0] load_keep;
    logic                   load_last;
    logic [`DEST_WIDTH-1:0] load_dest;

    // Gated by aresetn so both readies read 0 while reset is held.
    assign cmd_ready     = aresetn && (state_q == ST_IDLE) && out_ready;
    assign s_axis_tready = aresetn && (state_q == ST_PAYLOAD) && out_ready;
    assign cmd_fire      = cmd_valid && cmd_ready;
    assign pay_fire      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dest_d     = dest_q;
        load_valid = 1'b0;
        load_data  = '0;
        load_keep  = '0;
        load_last  = 1'b0;
        load_dest  = dest_q;
        if (cmd_fire) begin
            load_valid = 1'b1;
            load_data  = make_header(cmd_dest, ADDRESS, cmd_len);
            load_keep  = '1;
            load_last  = (cmd_len == 8'd0);
            load_dest  = cmd_dest;
            dest_d     = cmd_dest;
            cnt_d      = cmd_len;
            if (cmd_len != 8'd0) begin
                state_d = ST_PAYLOAD;
            end
        end else if (pay_fire) begin
            // Packet end comes from the counter alone, never from s_axis_tlast.
            load_valid = 1'b1;
            load_data  = s_axis_tdata;
            load_keep  = s_axis_tkeep;
            load_last  = (cnt_q == 8'd1);
            cnt_d      = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
        end
    end

    axis_out_reg #(
        .DATA_W (`DATA_WIDTH),
        .KEEP_W (`KEEP_WIDTH),
        .ID_W   (`ID_WIDTH),
        .DEST_W (`DEST_WIDTH)
    ) u_out_reg (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .in_valid_i  (load_valid),
        .in_ready_o  (out_ready),
        .in_data_i   (load_data),
        .in_keep_i   (load_keep),
        .in_last_i   (load_last),
        .in_id_i     (ADDRESS),
        .in_dest_i   (load_dest),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready),
        .out_data_o  (m_axis_tdata),
        .out_keep_o  (m_axis_tkeep),
        .out_last_o  (m_axis_tlast),
        .out_id_o    (m_axis_tid),
        .out_dest_o  (m_axis_tdest)
    );

    assign busy      = (state_q != ST_IDLE) || m_axis_tvalid;
    assign dbg_state = state_q;

`ifdef PKT_FRAMER_ERRCNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (pay_fire && (s_axis_tlast != (cnt_q == 8'd1)) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 16'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
`endif

endmodule

// File: doc/pkt_framer.md
PKT_FRAMER -- requirements
Module: pkt_framer

Interface
REQ-001 Parameter ADDRESS, default 8'h00: this node's source address, written into header bits 55:48 and m_axis_tid.
REQ-002 Port aclk, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-003 Port aresetn, input, 1: reset, asynchronous and active-low.
REQ-004 Port cmd_valid, input, 1: a packet request is offered.
REQ-005 Port cmd_ready, output, 1: the framer accepts the request.
REQ-006 Port cmd_dest, input, 8: destination address for the request.
REQ-007 Port cmd_len, input, 8: number of payload beats, 0..255.
REQ-008 Ports s_axis_tdata/tkeep/tvalid/tready/tlast, in/in/in/out/in, `DATA_WIDTH/`KEEP_WIDTH/1/1/1: payload stream from the local endpoint.
REQ-009 Ports m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest, out/out/out/in/out/out/out, `DATA_WIDTH/`KEEP_WIDTH/1/1/1/`ID_WIDTH/`DEST_WIDTH: framed stream to the router.
REQ-010 Port busy, output, 1: high whenever state is not IDLE or the output register holds a beat.
REQ-011 Port err_count, output, 16: count of payload framing errors; present only under PKT_FRAMER_ERRCNT_EN.

Function
REQ-012 Header beat layout: 63:56 = cmd_dest, 55:48 = ADDRESS, 47:40 = cmd_len, 39:0 = 0, and tkeep = all ones.
REQ-013 States: IDLE and PAYLOAD; cmd_ready = (state==IDLE) && (output register empty || m_axis_tready).
REQ-014 On the cmd handshake, the header loads into the output register at that edge, so m_axis_tvalid rises 1 cycle after the handshake.
REQ-015 On the cmd handshake, tdest latches cmd_dest, tid = ADDRESS, and beat counter = cmd_len.
REQ-016 cmd_len==0: the header carries tlast=1 and state stays IDLE; cmd_len>0: the header carries tlast=0 and state goes to PAYLOAD.
REQ-017 In PAYLOAD, s_axis_tready = output register empty || m_axis_tready; throughput is 1 beat/cycle with no bubble between header and payload.
REQ-018 Each accepted payload beat passes tdata/tkeep unchanged into the output register and decrements the counter.
REQ-019 The beat accepted with counter==1 carries m_axis_tlast=1, and state returns to IDLE at that edge.
REQ-020 m_axis tlast is generated from the counter only; upstream s_axis_tlast never truncates or extends a packet.
REQ-021 The output register holds data/valid stable while m_axis_tvalid && !m_axis_tready.
REQ-022 A new cmd is accepted in the same cycle that the last payload beat drains.
REQ-023 tid/tdest stay constant for every beat of a packet.
REQ-024 s_axis_tready = 0 in IDLE.

Reset
REQ-025 On aresetn low, immediately: state = IDLE, counter = 0, output register empty, m_axis_tvalid/tlast/tdata/tkeep/tid/tdest = 0, cmd_ready = 0, s_axis_tready = 0, busy = 0, err_count = 0.
REQ-026 A reset mid-packet discards the packet; no tlast beat is emitted for it.
REQ-027 After aresetn deasserts, cmd_ready = 1 from the first clock edge.

Configuration
REQ-028 With PKT_FRAMER_ERRCNT_EN defined, err_count increments (saturating at 16'hFFFF) on each accepted payload beat where s_axis_tlast != (counter==1).
REQ-029 Without PKT_FRAMER_ERRCNT_EN, the err_count port and counter are absent and s_axis_tlast is ignored.

Structure
REQ-030 Shared package pebb_pkg holds: header field offsets/widths, the framer_state_t enum, and a make_header(dest, src, len) function, all reused by router.
REQ-031 The output register is a sub-module, axis_out_reg (1-entry AXI-S pipeline register).

Verification
REQ-032 Reset: aresetn pulsed mid-PAYLOAD -> all outputs 0 asynchronously, the next cmd is framed correctly.
REQ-033 Length 0: cmd dest=8'h05, len=0, ADDRESS=8'h02 -> one beat 64'h0502_0000_0000_0000 with tlast=1, tdest=5.
REQ-034 Streaming: len=4, tready held 1, payload 1..4 -> header then 1,2,3,4 on 5 consecutive cycles, tlast on beat 4.
REQ-035 Backpressure: len=3, random m_axis_tready -> no beat lost or duplicated, data stable while stalled.
REQ-036 Back-to-back: two cmds len=2 issued continuously -> second header follows first tlast with zero idle cycles.
REQ-037 Error count (macro on): len=3 with s_axis_tlast on beat 2 -> err_count increments at beat 2 and again at beat 3, output tlast only on beat 3.
